vector_wb_serializer: RTL and testbench

- Write-back end of the 5-lane vector datapath.
- Accepts one full vector result from the vector ALU in a single valid/ready handshake and stores it.
- Then emits the vector to the scalar memory/register write port, one element per cycle, with a valid/ready handshake and a strided address.
- Sits between the vector ALU outputs and the data-memory write interface.

---
 rtl/vec_pkg.sv | 17 +
 rtl/vec_next_lane.sv | 27 ++
 rtl/vector_wb_serializer.sv | 165 ++++++++++++++++
 tb/tb_vector_wb_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector write-back path: lane geometry,
// the serializer state type and the lane-index type.
package vec_pkg;

    localparam int LANES  = 5;
    localparam int WIDTH  = 32;
    localparam int STRIDE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } vec_wb_state_t;

    // Lane index; wide enough for up to 8 lanes.
    typedef logic [2:0] lane_t;

endpackage

// File: rtl/vec_next_lane.sv
// Priority finder: lowest set mask bit at or above 'start'.
// 'start' is one bit wider than a lane index so "above the last lane"
// can be expressed without wrapping back to lane 0.
module vec_next_lane
    import vec_pkg::*;
#(
    parameter int N_LANES = 5
) (
    input  logic [N_LANES-1:0] mask,
    input  logic [3:0]         start,
    output logic               found,
    output lane_t              lane
);

    // Scan from the top down so the lowest qualifying lane wins.
    always_comb begin
        found = 1'b0;
        lane  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) begin
                found = 1'b1;
                lane  = lane_t'(i);
            end
        end
    end

endmodule

// File: rtl/vector_wb_serializer.sv
// Vector write-back serializer: takes a whole vector in one handshake,
// then streams it out one element per beat with a strided address.
// Optional lane masking is enabled by defining VECTOR_WB_MASK_EN.
module vector_wb_serializer
    import vec_pkg::*;
#(
    parameter int LANES  = vec_pkg::LANES,
    parameter int WIDTH  = vec_pkg::WIDTH,
    parameter int ADDR_W = 32,
    parameter int STRIDE = vec_pkg::STRIDE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] vec_in,
    input  logic [ADDR_W-1:0]      in_base_addr,
`ifdef VECTOR_WB_MASK_EN
    input  logic [LANES-1:0]       in_mask,
`endif
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [WIDTH-1:0]       wr_data,
    output logic [2:0]             wr_lane,
    output logic                   wr_last,
    output logic                   busy,
    output logic                   done
);

    vec_wb_state_t     state_q, state_d;
    lane_t             lane_q, lane_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  buf_q [LANES];
    logic [WIDTH-1:0]  vec_lane [LANES];

    logic  accept;
    logic  xfer;
    logic  is_last;
    logic  first_found;
    lane_t first_lane;
    lane_t next_lane;

    assign accept = in_valid && in_ready;
    assign xfer   = wr_valid && wr_ready;

    // Split the packed input vector into per-lane words and hold them.
    // The buffer carries no reset: its content is only observed in SEND.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign vec_lane[gi] = vec_in[gi*WIDTH +: WIDTH];

        // Capture lane gi on acceptance.
        always_ff @(posedge clk) begin
            if (accept) begin
                buf_q[gi] <= vec_lane[gi];
            end
        end
    end

`ifdef VECTOR_WB_MASK_EN
    logic [LANES-1:0] mask_q;
    logic             next_found;

    // Mask is captured alongside the vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= in_mask;
        end
    end

    // First enabled lane of the incoming vector.
    vec_next_lane #(.N_LANES(LANES)) u_first (
        .mask  (in_mask),
        .start (4'd0),
        .found (first_found),
        .lane  (first_lane)
    );

    // Next enabled lane strictly above the one being sent.
    vec_next_lane #(.N_LANES(LANES)) u_next (
        .mask  (mask_q),
        .start ({1'b0, lane_q} + 4'd1),
        .found (next_found),
        .lane  (next_lane)
    );

    assign is_last = !next_found;
`else
    assign first_found = 1'b1;
    assign first_lane  = '0;
    assign next_lane   = lane_q + 3'd1;
    assign is_last     = (lane_q == lane_t'(LANES - 1));
`endif

    // Next-state logic: accept in IDLE, advance one lane per transfer in SEND.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        base_d  = base_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d = in_base_addr;
                    if (first_found) begin
                        lane_d  = first_lane;
                        state_d = SEND;
                    end else begin
                        // Nothing enabled: the vector completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lane_d = next_lane;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            base_q  <= base_d;
            done_q  <= done_d;
        end
    end

    // Outputs are decoded from registered state; beat fields read as zero
    // in IDLE and only change on a transfer, so they hold under backpressure.
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == SEND);
        wr_valid = (state_q == SEND);
        done     = done_q;
        wr_addr  = '0;
        wr_data  = '0;
        wr_lane  = '0;
        wr_last  = 1'b0;
        if (state_q == SEND) begin
            wr_addr = base_q + (ADDR_W'(lane_q) * ADDR_W'(STRIDE));
            wr_data = buf_q[lane_q];
            wr_lane = lane_q;
            wr_last = is_last;
        end
    end

endmodule

// File: tb/tb_vector_wb_serializer.sv
// Directed bench for vector_wb_serializer. Builds with or without
// VECTOR_WB_MASK_EN; the masked steps only run when it is defined.
module tb_vector_wb_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] vec_in;
    logic [31:0]  in_base_addr;
`ifdef VECTOR_WB_MASK_EN
    logic [4:0]   in_mask;
`endif
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [2:0]   wr_lane;
    logic         wr_last;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int beats = 0;

    always #5 clk = ~clk;

    vector_wb_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vec_in       (vec_in),
        .in_base_addr (in_base_addr),
`ifdef VECTOR_WB_MASK_EN
        .in_mask      (in_mask),
`endif
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_lane      (wr_lane),
        .wr_last      (wr_last),
        .busy         (busy),
        .done         (done)
    );

    // Count accepted write beats.
    always @(posedge clk) begin
        if (!reset && wr_valid && wr_ready) beats <= beats + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mkvec(input logic [31:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // One unmasked vector; optional stall of stall_n cycles on stall_lane.
    task automatic run_vec(input logic [159:0] v, input logic [31:0] base,
                           input int stall_lane, input int stall_n);
        int b0;
        logic [31:0] ea, ed;
        in_valid     = 1'b1;
        vec_in       = v;
        in_base_addr = base;
`ifdef VECTOR_WB_MASK_EN
        in_mask      = 5'b11111;
`endif
        wr_ready     = 1'b1;
        step();
        in_valid = 1'b0;
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            ea = base + 32'(i * 4);
            ed = v[i*32 +: 32];
            if (i == stall_lane) begin
                wr_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk("stall_valid", 32'(wr_valid), 32'd1);
                    chk("stall_addr", wr_addr, ea);
                    chk("stall_data", wr_data, ed);
                    chk("stall_lane", 32'(wr_lane), 32'(i));
                end
                wr_ready = 1'b1;
            end
            chk("beat_valid", 32'(wr_valid), 32'd1);
            chk("beat_inready", 32'(in_ready), 32'd0);
            chk("beat_busy", 32'(busy), 32'd1);
            chk("beat_lane", 32'(wr_lane), 32'(i));
            chk("beat_addr", wr_addr, ea);
            chk("beat_data", wr_data, ed);
            chk("beat_last", 32'(wr_last), 32'(i == 4));
            chk("beat_done", 32'(done), 32'd0);
            step();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(wr_valid), 32'd0);
        chk("done_inready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("beat_count", 32'(beats - b0), 32'd5);
        step();
        chk("done_once", 32'(done), 32'd0);
        $display("vector base=%08h stall_lane=%0d stall_n=%0d complete", base, stall_lane, stall_n);
    endtask

    initial begin
        logic [159:0] va, vb;
        reset        = 1'b1;
        in_valid     = 1'b0;
        vec_in       = '0;
        in_base_addr = '0;
        wr_ready     = 1'b0;
`ifdef VECTOR_WB_MASK_EN
        in_mask      = '0;
`endif
        step();
        step();
        chk("rst_inready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_addr", wr_addr, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_lane", 32'(wr_lane), 32'd0);
        chk("rst_last", 32'(wr_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_inready", 32'(in_ready), 32'd1);
            chk("idle_valid", 32'(wr_valid), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end
        $display("idle check complete");

        va = mkvec(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
        run_vec(va, 32'h100, -1, 0);           // basic
        run_vec(va, 32'h100, 2, 3);            // backpressure on lane 2
        run_vec(mkvec(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4), 32'hFFFF_FFF8, -1, 0); // wrap

        // Reset after the lane-1 transfer.
        in_valid = 1'b1; vec_in = va; in_base_addr = 32'h200; wr_ready = 1'b1;
`ifdef VECTOR_WB_MASK_EN
        in_mask = 5'b11111;
`endif
        step();
        in_valid = 1'b0;
        step();                                 // lane 0 transfers
        chk("pre_rst_lane", 32'(wr_lane), 32'd1);
        reset = 1'b1;                           // lane 1 transfers at the same edge
        step();
        reset = 1'b0;
        step();
        chk("abort_valid", 32'(wr_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_inready", 32'(in_ready), 32'd1);
        chk("abort_addr", wr_addr, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_nodone", 32'(done), 32'd0);
            chk("abort_novalid", 32'(wr_valid), 32'd0);
        end
        $display("mid-vector reset complete");
        run_vec(va, 32'h300, -1, 0);

        // in_valid held through SEND: second vector waits, then is taken at N+6.
        vb = mkvec(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        in_valid = 1'b1; vec_in = va; in_base_addr = 32'h400; wr_ready = 1'b1;
        step();
        vec_in = vb; in_base_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            chk("hold_inready", 32'(in_ready), 32'd0);
            chk("hold_data", wr_data, va[i*32 +: 32]);
            chk("hold_addr", wr_addr, 32'h400 + 32'(i * 4));
            step();
        end
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_accept_ready", 32'(in_ready), 32'd1);
        step();                                 // vb accepted here
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("second_lane", 32'(wr_lane), 32'(i));
            chk("second_data", wr_data, vb[i*32 +: 32]);
            chk("second_addr", wr_addr, 32'h500 + 32'(i * 4));
            step();
        end
        chk("second_done", 32'(done), 32'd1);
        step();
        $display("busy gating complete");

`ifdef VECTOR_WB_MASK_EN
        // Mask 10010: lanes 1 and 4 only.
        in_valid = 1'b1; vec_in = va; in_base_addr = 32'h600; in_mask = 5'b10010;
        step();
        in_valid = 1'b0;
        chk("m_lane1", 32'(wr_lane), 32'd1);
        chk("m_addr1", wr_addr, 32'h604);
        chk("m_data1", wr_data, 32'h22);
        chk("m_last1", 32'(wr_last), 32'd0);
        step();
        chk("m_lane4", 32'(wr_lane), 32'd4);
        chk("m_addr4", wr_addr, 32'h610);
        chk("m_data4", wr_data, 32'h55);
        chk("m_last4", 32'(wr_last), 32'd1);
        step();
        chk("m_done", 32'(done), 32'd1);
        chk("m_valid_off", 32'(wr_valid), 32'd0);
        step();
        $display("mask 10010 complete");

        // Mask 0: done at N+1, no beats.
        in_valid = 1'b1; in_mask = 5'b00000;
        step();
        in_valid = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_valid", 32'(wr_valid), 32'd0);
        chk("z_inready", 32'(in_ready), 32'd1);
        step();
        chk("z_done_once", 32'(done), 32'd0);
        $display("mask 00000 complete");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
